aes_key_sched_ctrl: RTL and testbench

Sequencer for AES-128 key expansion. It time-shares one external 4-byte s-box instance, the SubWord resource, across all rounds and produces round keys 0..NUM_ROUNDS one per valid/ready handshake. It sits between the key register interface and the cipher round datapath. The cipher consumes each round key as it is presented, so the full 44-word schedule is never stored.

---
 rtl/aes_key_sched_ctrl.sv | 82 ++++++++
 tb/tb_aes_key_sched_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion sequencer sharing one external SubWord s-box
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key_in,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, PRESENT, SUB} state_e;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  state_e        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          done_q, done_d;
  logic [31:0]   t, w0, w1, w2, w3;
  assign sub_in   = {key_q[23:0], key_q[31:24]};
  assign t        = sub_out ^ {rcon_q, 24'h0};
  assign w0       = key_q[127:96] ^ t;
  assign w1       = key_q[95:64] ^ w0;
  assign w2       = key_q[63:32] ^ w1;
  assign w3       = key_q[31:0] ^ w2;
  assign rk_valid = state_q == PRESENT;
  assign rk_data  = key_q;
  assign rk_round = cnt_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  // next-state: load key on start, present until handshake, one SUB cycle per round
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        state_d = PRESENT;
        key_d   = key_in;
        cnt_d   = '0;
        rcon_d  = 8'h01;
      end
      PRESENT: if (rk_ready) begin
        state_d = (cnt_q == LAST) ? IDLE : SUB;
        done_d  = cnt_q == LAST;
      end
      SUB: begin
        state_d = PRESENT;
        key_d   = {w0, w1, w2, w3};
        cnt_d   = cnt_q + 4'd1;
        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and key registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: randomized and directed checks of the key schedule sequencer
module tb_aes_key_sched_ctrl;
  localparam int NR = 10;
  logic         clk = 1'b0;
  logic         n_rst, start, abort, rk_ready, start1, rk_ready1;
  logic [127:0] key_in;
  logic [31:0]  sub_in, sub_out, sub_in1, sub_out1;
  logic         rk_valid, busy, done, rk_valid1, busy1, done1;
  logic [127:0] rk_data, rk_data1;
  logic [3:0]   rk_round, rk_round1;
  logic [127:0] got [0:NR];
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(logic [7:0] x, int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] b);
    logic [7:0] inv = '0;
    for (int x = 1; x < 256; x++) if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] ref_rk(logic [127:0] k, int r);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 4*(r+1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  assign sub_out  = subword(sub_in);
  assign sub_out1 = subword(sub_in1);

  aes_key_sched_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .key_in(key_in),
    .sub_in(sub_in), .sub_out(sub_out), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_round(rk_round), .busy(busy), .done(done));

  aes_key_sched_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .abort(abort), .key_in(key_in),
    .sub_in(sub_in1), .sub_out(sub_out1), .rk_valid(rk_valid1), .rk_ready(rk_ready1),
    .rk_data(rk_data1), .rk_round(rk_round1), .busy(busy1), .done(done1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [127:0] k, input bit rnd, input int stall_r,
                     input int ign_r, input int kill_r, input bit kill_rst);
    int r = 0, e = 0, nst = 0, stall = 0;
    bit rdy;
    key_in = k;
    start = 1'b1;
    step();
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    while (e < 200) begin
      chk("valid", rk_valid, 1);
      chk("round", rk_round, r);
      chk("data", rk_data, ref_rk(k, r));
      chk("busy", busy, 1);
      got[r] = rk_data;
      if (r == kill_r) begin
        if (kill_rst) n_rst = 1'b0; else abort = 1'b1;
        rk_ready = 1'b1;
        step();
        n_rst = 1'b1;
        abort = 1'b0;
        chk("kill_valid", rk_valid, 0);
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        if (kill_rst) begin
          chk("rst_round", rk_round, 0);
          chk("rst_data", rk_data, 0);
        end else begin
          step();
          chk("abort_hold", rk_data, ref_rk(k, r));
          chk("abort_done", done, 0);
          chk("abort_valid", rk_valid, 0);
        end
        return;
      end
      rdy = (r == stall_r && stall < 5) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (r == stall_r && !rdy) stall++;
      if (r == ign_r) begin
        start = 1'b1;
        key_in = ~k;
      end
      rk_ready = rdy;
      step();
      start = 1'b0;
      e++;
      if (!rdy) begin
        nst++;
        continue;
      end
      if (r == NR) break;
      chk("sub_gap", rk_valid, 0);
      chk("sub_busy", busy, 1);
      chk("sub_done", done, 0);
      step();
      e++;
      r++;
    end
    chk("done", done, 1);
    chk("last_edges", e, 2*NR + 1 + nst);
    chk("end_valid", rk_valid, 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    start1 = 1'b0; rk_ready1 = 1'b0; key_in = '0;
    step(); step(); step();
    chk("rst_valid", rk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_round", rk_round, 0);
    chk("rst_data", rk_data, 0);
    chk("rst_subin", sub_in, 0);
    n_rst = 1'b1;
    step();
    run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, -1, -1, -1, 0);
    chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step();
    chk("done_pulse", done, 0);
    run(128'h0, 0, -1, -1, -1, 0);
    chk("zero_r1", got[1], 128'h62636363626363636263636362636363);
    chk("zero_r2", got[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    run({$urandom, $urandom, $urandom, $urandom}, 1, 4, 2, -1, 0);
    run({$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, 6, 0);
    run({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 3, 1);
    run({$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, -1, 0);
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_valid", rk_valid, 0);
    chk("abort_start_busy", busy, 0);
    for (int i = 0; i < 3; i++) run({$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, -1, 0);
    step();
    key_in = '0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("n1_r0_valid", rk_valid1, 1);
    chk("n1_r0_round", rk_round1, 0);
    chk("n1_r0_data", rk_data1, 0);
    rk_ready1 = 1'b1;
    step();
    chk("n1_sub_valid", rk_valid1, 0);
    step();
    chk("n1_r1_valid", rk_valid1, 1);
    chk("n1_r1_round", rk_round1, 1);
    chk("n1_r1_data", rk_data1, ref_rk(128'h0, 1));
    chk("n1_r1_const", rk_data1, 128'h62636363626363636263636362636363);
    step();
    chk("n1_done", done1, 1);
    chk("n1_end_valid", rk_valid1, 0);
    chk("n1_end_busy", busy1, 0);
    step();
    chk("n1_done_pulse", done1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
